dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data-cache controller between the pipeline memory stage and main memory. It drives an external tag/data array (combinational read, write at clock edge) and a pipelined word-wide memory. It produces the stall, done, request and hit strobes that the memory stage and the processor bench consume (DCacheReq/DCacheHit). Lines are 4 words of 16 bits, with 256 lines. Address split: tag[15:11], index[10:3], offset[2:1]; addr[0] must be 0.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_stat_ctr.sv | 23 ++
 rtl/dcache_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped data-cache controller.
package dcache_pkg;

   localparam int unsigned TAG_W      = 5;
   localparam int unsigned IDX_W      = 8;
   localparam int unsigned OFF_W      = 3;
   localparam int unsigned LINE_WORDS = 4;

   typedef enum logic [3:0] {
      IDLE,
      WB0, WB1, WB2, WB3,
      FILL0, FILL1, FILL2, FILL3, FILL4, FILL5,
      RETRY
   } state_t;

endpackage

// File: rtl/dcache_stat_ctr.sv
// 16-bit saturating event counter used for cache statistics.
module dcache_stat_ctr (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Define DCACHE_STATS_EN to build the req_count/hit_count statistics counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned MEM_LAT   = 2,
   parameter int unsigned NUM_LINES = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Rd,
   input  logic             Wr,
   input  logic [15:0]      Addr,
   input  logic [15:0]      DataIn,
   output logic [15:0]      DataOut,
   output logic             Done,
   output logic             Stall,
   output logic             CacheHit,
   output logic             CacheReq,
   output logic             err,
   output logic             c_enable,
   output logic             c_comp,
   output logic             c_write,
   output logic             c_valid_in,
   output logic [IDX_W-1:0] c_index,
   output logic [OFF_W-1:0] c_offset,
   output logic [TAG_W-1:0] c_tag_in,
   output logic [15:0]      c_data_in,
   input  logic             c_hit,
   input  logic             c_dirty,
   input  logic             c_valid,
   input  logic [TAG_W-1:0] c_tag_out,
   input  logic [15:0]      c_data_out,
   output logic [15:0]      m_addr,
   output logic [15:0]      m_data_in,
   output logic             m_wr,
   output logic             m_rd,
   input  logic [15:0]      m_data_out,
   input  logic             m_stall,
   output logic [15:0]      req_count,
   output logic [15:0]      hit_count
);

   localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
   localparam logic [2:0]  FILL_WR0 = 3'(MEM_LAT);

   state_t              state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d, victim_q, victim_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic [1:0]          off_q, off_d;
   logic [15:0]         data_q, data_d;
   logic                wr_q, wr_d, vdirty_q, vdirty_d, hold_q, hold_d;

   logic [3:0] st;
   logic [1:0] wb_k, wr_word;
   logic [2:0] fill_k;
   logic       req, bad;

   assign st      = state_q;
   assign wb_k    = 2'(st - WB0);
   assign fill_k  = 3'(st - FILL0);
   assign wr_word = 2'(fill_k - FILL_WR0);
   assign req     = Rd ^ Wr;
   assign bad     = (Rd && Wr) || ((Rd || Wr) && Addr[0]);

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      idx_d    = idx_q;
      off_d    = off_q;
      data_d   = data_q;
      wr_d     = wr_q;
      victim_d = victim_q;
      vdirty_d = vdirty_q;
      hold_d   = 1'b0;
      DataOut  = '0;
      Done     = 1'b0;
      Stall    = 1'b0;
      CacheHit = 1'b0;
      CacheReq = 1'b0;
      err      = 1'b0;
      c_enable = 1'b0;
      c_comp   = 1'b0;
      c_write  = 1'b0;
      c_valid_in = 1'b0;
      c_index  = '0;
      c_offset = '0;
      c_tag_in = '0;
      c_data_in = '0;
      m_addr   = '0;
      m_data_in = '0;
      m_wr     = 1'b0;
      m_rd     = 1'b0;
      // Everything, including the combinational request path, is silent in reset.
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (hold_q) begin
                  // Miss already latched; wait for memory without re-accessing the array.
                  Stall = 1'b1;
                  if (m_stall) hold_d  = 1'b1;
                  else         state_d = vdirty_q ? WB0 : FILL0;
               end else begin
                  err = bad;
                  if (req && !bad) begin
                     c_enable  = 1'b1;
                     c_comp    = 1'b1;
                     c_write   = Wr;
                     c_index   = Addr[10:3];
                     c_offset  = {Addr[2:1], 1'b0};
                     c_tag_in  = Addr[15:11];
                     c_data_in = DataIn;
                     CacheReq  = 1'b1;
                     if (c_hit && c_valid) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = c_data_out;
                     end else begin
                        Stall    = 1'b1;
                        tag_d    = Addr[15:11];
                        idx_d    = Addr[10:3];
                        off_d    = Addr[2:1];
                        data_d   = DataIn;
                        wr_d     = Wr;
                        victim_d = c_tag_out;
                        vdirty_d = c_valid && c_dirty;
                        if (m_stall) hold_d  = 1'b1;
                        else         state_d = (c_valid && c_dirty) ? WB0 : FILL0;
                     end
                  end
               end
            end
            WB0, WB1, WB2, WB3: begin
               Stall     = 1'b1;
               c_enable  = 1'b1;
               c_index   = idx_q;
               c_offset  = {wb_k, 1'b0};
               m_wr      = 1'b1;
               m_addr    = {victim_q, idx_q, wb_k, 1'b0};
               m_data_in = c_data_out;
               if (state_q == WB3) begin
                  if (!m_stall) state_d = FILL0;
               end else begin
                  state_d = state_t'(st + 4'd1);
               end
            end
            FILL0, FILL1, FILL2, FILL3, FILL4, FILL5: begin
               Stall = 1'b1;
               if (fill_k < 3'd4) begin
                  m_rd   = 1'b1;
                  m_addr = {tag_q, idx_q, fill_k[1:0], 1'b0};
               end
               if (fill_k >= FILL_WR0) begin
                  c_enable   = 1'b1;
                  c_write    = 1'b1;
                  c_index    = idx_q;
                  c_offset   = {wr_word, 1'b0};
                  c_tag_in   = tag_q;
                  c_data_in  = m_data_out;
                  c_valid_in = (state_q == FILL5);
               end
               state_d = (state_q == FILL5) ? RETRY : state_t'(st + 4'd1);
            end
            RETRY: begin
               c_enable  = 1'b1;
               c_comp    = 1'b1;
               c_write   = wr_q;
               c_index   = idx_q;
               c_offset  = {off_q, 1'b0};
               c_tag_in  = tag_q;
               c_data_in = data_q;
               Done      = 1'b1;
               DataOut   = c_data_out;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         idx_q    <= '0;
         off_q    <= '0;
         data_q   <= '0;
         wr_q     <= 1'b0;
         victim_q <= '0;
         vdirty_q <= 1'b0;
         hold_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         idx_q    <= idx_d;
         off_q    <= off_d;
         data_q   <= data_d;
         wr_q     <= wr_d;
         victim_q <= victim_d;
         vdirty_q <= vdirty_d;
         hold_q   <= hold_d;
      end
   end

`ifdef DCACHE_STATS_EN
   dcache_stat_ctr u_req_ctr (.clk(clk), .rst(rst), .inc(CacheReq), .count(req_count));
   dcache_stat_ctr u_hit_ctr (.clk(clk), .rst(rst), .inc(CacheHit), .count(hit_count));
`else
   assign req_count = '0;
   assign hit_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a tag/data array model and a 2-cycle pipelined memory.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        Rd, Wr, m_stall;
   logic [15:0] Addr, DataIn, DataOut;
   logic        Done, Stall, CacheHit, CacheReq, err;
   logic        c_enable, c_comp, c_write, c_valid_in;
   logic [7:0]  c_index;
   logic [2:0]  c_offset;
   logic [4:0]  c_tag_in, c_tag_out;
   logic [15:0] c_data_in, c_data_out;
   logic        c_hit, c_dirty, c_valid;
   logic [15:0] m_addr, m_data_in, m_data_out;
   logic        m_wr, m_rd;
   logic [15:0] req_count, hit_count;

   always #5 clk = ~clk;

   dcache_ctrl #(.MEM_LAT(2), .NUM_LINES(256)) dut (
      .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
      .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
      .CacheReq(CacheReq), .err(err), .c_enable(c_enable), .c_comp(c_comp),
      .c_write(c_write), .c_valid_in(c_valid_in), .c_index(c_index),
      .c_offset(c_offset), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
      .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
      .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in),
      .m_wr(m_wr), .m_rd(m_rd), .m_data_out(m_data_out), .m_stall(m_stall),
      .req_count(req_count), .hit_count(hit_count)
   );

   // Tag/data array model: combinational read, write at the clock edge.
   logic [4:0]  a_tag   [0:255];
   logic        a_valid [0:255];
   logic        a_dirty [0:255];
   logic [15:0] a_data  [0:255][0:3];

   assign c_hit      = (a_tag[c_index] == c_tag_in);
   assign c_valid    = a_valid[c_index];
   assign c_dirty    = a_dirty[c_index];
   assign c_tag_out  = a_tag[c_index];
   assign c_data_out = a_data[c_index][c_offset[2:1]];

   always @(posedge clk) begin
      if (c_enable && c_write) begin
         if (c_comp) begin
            if (a_valid[c_index] && (a_tag[c_index] == c_tag_in)) begin
               a_data[c_index][c_offset[2:1]] <= c_data_in;
               a_dirty[c_index] <= 1'b1;
            end
         end else begin
            a_data[c_index][c_offset[2:1]] <= c_data_in;
            a_tag[c_index]   <= c_tag_in;
            a_valid[c_index] <= c_valid_in;
            a_dirty[c_index] <= 1'b0;
         end
      end
   end

   // Main memory: word = byte_addr ^ 16'h5A5A, except 0x0010 = 16'hBEEF.
   logic [15:0] mem [0:32767];
   logic [15:0] ms1, ms2;
   assign m_data_out = ms2;

   always @(posedge clk) begin
      if (m_wr) mem[m_addr[15:1]] <= m_data_in;
      ms1 <= m_rd ? mem[m_addr[15:1]] : 16'h0000;
      ms2 <= ms1;
   end

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2) ^ 16'h5A5A;
      mem[16'h0010 >> 1] = 16'hBEEF;
      for (int i = 0; i < 256; i++) begin
         a_tag[i] = '0; a_valid[i] = 1'b0; a_dirty[i] = 1'b0;
         for (int j = 0; j < 4; j++) a_data[i][j] = '0;
      end
      ms1 = '0; ms2 = '0;
   end

   // Memory traffic log.
   logic [15:0] rd_log[$], wa_log[$], wd_log[$];
   int          req_seen;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_rd) rd_log.push_back(m_addr);
         if (m_wr) begin wa_log.push_back(m_addr); wd_log.push_back(m_data_in); end
         if (CacheReq) req_seen++;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic clear_logs();
      rd_log.delete(); wa_log.delete(); wd_log.delete(); req_seen = 0;
   endtask

   // Issue one request at posedge+1; cyc counts cycles from the request cycle to Done.
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output int cyc, output logic [15:0] dout, output logic hit);
      logic seen;
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      cyc = 0; seen = 1'b0; dout = '0; hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (Done) begin dout = DataOut; hit = CacheHit; seen = 1'b1; break; end
         cyc++;
      end
      if (!seen) chk("done_timeout", 32'(seen), 32'd1);
      @(posedge clk); #1;
      Rd = 1'b0; Wr = 1'b0;
   endtask

   int          cyc;
   logic [15:0] dout;
   logic        hit;

   initial begin
      rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = '0; m_stall = 1'b0;
      req_seen = 0;
      #12;
      chk("rst_done",   32'(Done), 'd0);
      chk("rst_stall",  32'(Stall), 'd0);
      chk("rst_cenable", 32'(c_enable), 'd0);
      chk("rst_req",    32'(CacheReq), 'd0);
      chk("rst_reqcnt", 32'(req_count), 'd0);
      Rd = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // Cold load
      clear_logs();
      do_req(1'b1, 1'b0, 16'h0010, '0, cyc, dout, hit);
      chk("cold_cyc",  32'(cyc), 'd7);
      chk("cold_data", 32'(dout), 'hBEEF);
      chk("cold_hit",  32'(hit), 'd0);
      chk("cold_nrd",  32'(rd_log.size()), 'd4);
      for (int i = 0; i < 4; i++) chk("cold_rdaddr", 32'(rd_log[i]), 32'(16'h0010 + 16'(2 * i)));
      chk("cold_reqs", 32'(req_seen), 'd1);

      // Repeat load hits
      do_req(1'b1, 1'b0, 16'h0012, '0, cyc, dout, hit);
      chk("hit_cyc",  32'(cyc), 'd0);
      chk("hit_data", 32'(dout), 'h5A48);
      chk("hit_hit",  32'(hit), 'd1);
`ifdef DCACHE_STATS_EN
      chk("stat_req", 32'(req_count), 'd2);
      chk("stat_hit", 32'(hit_count), 'd1);
`else
      chk("stat_req", 32'(req_count), 'd0);
      chk("stat_hit", 32'(hit_count), 'd0);
`endif

      // Store hit then conflicting load forces a write-back
      do_req(1'b0, 1'b1, 16'h0010, 16'h1234, cyc, dout, hit);
      chk("st_cyc", 32'(cyc), 'd0);
      chk("st_hit", 32'(hit), 'd1);
      clear_logs();
      do_req(1'b1, 1'b0, 16'h0810, '0, cyc, dout, hit);
      chk("dirty_cyc",   32'(cyc), 'd11);
      chk("dirty_data",  32'(dout), 'h524A);
      chk("dirty_hit",   32'(hit), 'd0);
      chk("dirty_nwr",   32'(wa_log.size()), 'd4);
      chk("dirty_wa0",   32'(wa_log[0]), 'h0010);
      chk("dirty_wd0",   32'(wd_log[0]), 'h1234);
      chk("dirty_rd0",   32'(rd_log[0]), 'h0810);
      chk("dirty_mem10", 32'(mem[16'h0010 >> 1]), 'h1234);
      chk("dirty_mem12", 32'(mem[16'h0012 >> 1]), 'h5A48);

      // Memory busy for 3 cycles at miss detect
      clear_logs();
      m_stall = 1'b1;
      fork
         begin repeat (3) @(posedge clk); #1; m_stall = 1'b0; end
      join_none
      do_req(1'b1, 1'b0, 16'h0020, '0, cyc, dout, hit);
      chk("mstall_cyc",  32'(cyc), 'd10);
      chk("mstall_data", 32'(dout), 'h5A7A);
      chk("mstall_reqs", 32'(req_seen), 'd1);
      chk("mstall_rd0",  32'(rd_log[0]), 'h0020);

      // Reset in the middle of a fill
      Rd = 1'b1; Wr = 1'b0; Addr = 16'h0030;
      repeat (4) @(posedge clk);
      #2; rst = 1'b1; #1;
      chk("midrst_stall",   32'(Stall), 'd0);
      chk("midrst_done",    32'(Done), 'd0);
      chk("midrst_mrd",     32'(m_rd), 'd0);
      chk("midrst_cenable", 32'(c_enable), 'd0);
      chk("midrst_maddr",   32'(m_addr), 'd0);
      chk("midrst_reqcnt",  32'(req_count), 'd0);
      @(posedge clk); #1; rst = 1'b0; Rd = 1'b0;
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 16'h0030, '0, cyc, dout, hit);
      chk("postrst_cyc",  32'(cyc), 'd7);
      chk("postrst_hit",  32'(hit), 'd0);
      chk("postrst_data", 32'(dout), 'h5A6A);

      // Illegal requests
      clear_logs();
      Rd = 1'b1; Wr = 1'b1; Addr = 16'h0040;
      #4;
      chk("err_flag",    32'(err), 'd1);
      chk("err_done",    32'(Done), 'd0);
      chk("err_cenable", 32'(c_enable), 'd0);
      chk("err_mem",     32'({m_rd, m_wr}), 'd0);
      chk("err_req",     32'(CacheReq), 'd0);
      @(posedge clk); #1;
      Wr = 1'b0; Addr = 16'h0041;
      #4;
      chk("odd_err",     32'(err), 'd1);
      chk("odd_cenable", 32'(c_enable), 'd0);
      @(posedge clk); #1;
      Rd = 1'b0;
      @(posedge clk); #1;
      chk("err_nomem", 32'(rd_log.size() + wa_log.size()), 'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
